mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
- STARVE_LIMIT, 3: consecutive data grants allowed while if_req waits.
- TIMEOUT, 16: cycles in a grant state before a forced completion.
REQ-002 Clocking and reset SHALL be one clock, clk. Reset is rst, synchronous, active-high: rst=1 at a clk rising edge resets the block.
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- if_req  in  1  instruction fetch request.
- if_addr  in  32  fetch address.
- if_rdata  out  32  fetch data.
- if_ack  out  1  fetch completion pulse.
- d_req  in  1  data request.
- d_we  in  1  data write enable.
- d_sel  in  4  data byte select.
- d_addr  in  32  data address.
- d_wdata  in  32  write data.
- d_rdata  out  32  read data.
- d_ack  out  1  data completion pulse.
- m_req  out  1  memory request.
- m_we  out  1  memory write enable.
- m_sel  out  4  memory byte select.
- m_addr  out  32  memory address.
- m_wdata  out  32  memory write data.
- m_rdata  in  32  memory read data.
- m_ack  in  1  memory completion.
- bus_err  out  1  timeout pulse.
- stall_req  out  1  pipeline stall request to the core controller.

Function
REQ-004 The FSM SHALL have four states: IDLE, GNT_I, GNT_D, RESP.
REQ-005 Requests SHALL be sampled only in IDLE. Behaviour in IDLE:
- d_req alone -> GNT_D.
- if_req alone -> GNT_I.
- Both asserted -> GNT_D, unless starve_cnt == STARVE_LIMIT, in which case GNT_I.
- Neither asserted -> remain in IDLE.
REQ-006 On the grant transition, the chosen requester's address/we/sel/wdata SHALL be latched. m_* SHALL be driven from registers with m_req=1 for every cycle spent in GNT_I/GNT_D. GNT_I forces m_we=0, m_sel=4'b1111, m_wdata=0.
REQ-007 In a grant state, m_ack=1 SHALL:
- capture m_rdata into the granted requester's rdata register;
- move the FSM to RESP.
REQ-008 In RESP:
- the granted requester's ack SHALL be 1 for exactly one cycle;
- m_req SHALL be 0;
- requests SHALL be ignored;
- the next state SHALL be IDLE.
REQ-009 Minimum latency SHALL be: request seen in IDLE at cycle N, m_req at N+1, m_ack at N+1, ack at N+2, IDLE at N+3. Peak throughput is one transfer per 3 cycles.
REQ-010 Requesters SHALL hold req and all request fields stable until their ack. Req is deasserted or re-presented in the cycle after ack; the arbiter does not check this.
REQ-011 starve_cnt SHALL be a 3-bit register with these rules:
- +1 on each GNT_D entry while if_req=1, saturating at STARVE_LIMIT;
- cleared on GNT_I entry;
- cleared on GNT_D entry while if_req=0.
REQ-012 A timeout counter SHALL count cycles in a grant state and clear on state entry. If it reaches TIMEOUT-1 with m_ack=0:
- the FSM goes to RESP;
- the granted rdata is set to 0;
- bus_err pulses for 1 cycle, coincident with the ack.
REQ-013 m_ack SHALL be ignored outside the grant states.
REQ-014 stall_req SHALL be combinational: (if_req & ~if_ack) | (d_req & ~d_ack).
REQ-015 if_rdata/d_rdata SHALL hold their last captured value until the next completion for the same requester.

Reset
REQ-016 The cycle after rst=1 SHALL have:
- state=IDLE;
- m_req=0, m_we=0, m_sel=0, m_addr=0, m_wdata=0;
- if_ack=0, d_ack=0, bus_err=0;
- if_rdata=0, d_rdata=0;
- starve_cnt=0, timeout counter=0.
REQ-017 rst SHALL take priority over all FSM transitions in any state, including mid-grant. An aborted transfer produces no ack and no bus_err.

Verification
REQ-018 Single fetch: if_req=1, if_addr=0x00000010, m_ack=1 in the first m_req cycle, m_rdata=0x3C010001 -> m_addr=0x00000010 with m_we=0 one cycle after the request; if_ack=1 with if_rdata=0x3C010001 two cycles after the request.
REQ-019 Simultaneous requests: if_req=1 and d_req=1 (d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_sel=4'b1111), m_ack immediate -> data served first, then fetch; d_ack precedes if_ack by 3 cycles.
REQ-020 Starvation: if_req held with back-to-back d_req, STARVE_LIMIT=3 -> exactly 3 data grants, then 1 fetch grant, then starve_cnt=0.
REQ-021 Timeout: d_req with m_ack held 0, TIMEOUT=16 -> d_ack=1, bus_err=1, d_rdata=0 on the cycle after 16 grant cycles; the FSM then returns to IDLE.
REQ-022 Reset mid-grant: rst=1 during GNT_D before m_ack -> m_req=0 next cycle; no d_ack; after rst=0, a new if_req is served normally.
REQ-023 stall_req check: stall_req=1 from request assertion through the cycle before ack; stall_req=0 in the ack cycle.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-master (instruction fetch / data) arbiter onto a single memory bus.
// Data wins ties unless fetch has been starved; grants time out with bus_err.
module mem_bus_arbiter #(
    parameter int STARVE_LIMIT = 3,
    parameter int TIMEOUT      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_sel,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        m_req,
    output logic        m_we,
    output logic [3:0]  m_sel,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,
    output logic        bus_err,
    output logic        stall_req
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GNT_I = 2'd1;
    localparam logic [1:0] GNT_D = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam int              TO_W       = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT - 1);
    localparam logic [2:0]      STARVE_MAX = 3'(STARVE_LIMIT);

    logic [1:0]      state;
    logic [2:0]      starve_cnt;
    logic [TO_W-1:0] timeout_cnt;

    logic grant_d;
    logic timed_out;

    // Data wins a tie only while fetch has not yet been passed over STARVE_LIMIT times.
    assign grant_d   = d_req & (~if_req | (starve_cnt != STARVE_MAX));
    assign timed_out = (timeout_cnt == TO_LAST);

    assign stall_req = (if_req & ~if_ack) | (d_req & ~d_ack);

    // NOTE: synchronous reset lives inside the clocked block, and every state update
    // uses <= so all registers see the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            starve_cnt  <= '0;
            timeout_cnt <= '0;
            m_req       <= 1'b0;
            m_we        <= 1'b0;
            m_sel       <= '0;
            m_addr      <= '0;
            m_wdata     <= '0;
            if_ack      <= 1'b0;
            d_ack       <= 1'b0;
            bus_err     <= 1'b0;
            if_rdata    <= '0;
            d_rdata     <= '0;
        end else begin
            // Completion strobes default low so they last exactly the RESP cycle.
            if_ack  <= 1'b0;
            d_ack   <= 1'b0;
            bus_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state       <= GNT_D;
                        timeout_cnt <= '0;
                        m_req       <= 1'b1;
                        m_we        <= d_we;
                        m_sel       <= d_sel;
                        m_addr      <= d_addr;
                        m_wdata     <= d_wdata;
                        if (!if_req)
                            starve_cnt <= '0;
                        else if (starve_cnt != STARVE_MAX)
                            starve_cnt <= starve_cnt + 3'd1;
                    end else if (if_req) begin
                        state       <= GNT_I;
                        timeout_cnt <= '0;
                        starve_cnt  <= '0;
                        m_req       <= 1'b1;
                        m_we        <= 1'b0;
                        m_sel       <= 4'b1111;
                        m_addr      <= if_addr;
                        m_wdata     <= '0;
                    end
                end

                GNT_I, GNT_D: begin
                    if (m_ack || timed_out) begin
                        state       <= RESP;
                        timeout_cnt <= '0;
                        m_req       <= 1'b0;
                        bus_err     <= ~m_ack;
                        if (state == GNT_I) begin
                            if_ack   <= 1'b1;
                            if_rdata <= m_ack ? m_rdata : 32'h0;
                        end else begin
                            d_ack    <= 1'b1;
                            d_rdata  <= m_ack ? m_rdata : 32'h0;
                        end
                    end else begin
                        timeout_cnt <= timeout_cnt + TO_W'(1);
                    end
                end

                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios followed by a
// randomized run against a transaction-level reference model.
module tb_mem_bus_arbiter;

    localparam int STARVE_LIMIT = 3;
    localparam int TIMEOUT      = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we, m_ack;
    logic [31:0] if_addr, d_addr, d_wdata, m_rdata;
    logic [3:0]  d_sel;
    logic [31:0] if_rdata, d_rdata, m_addr, m_wdata;
    logic        if_ack, d_ack, m_req, m_we, bus_err, stall_req;
    logic [3:0]  m_sel;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_no  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_no <= cyc_no + 1;

    mem_bus_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .m_req(m_req), .m_we(m_we), .m_sel(m_sel), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack),
        .bus_err(bus_err), .stall_req(stall_req)
    );

    // Outputs are sampled and inputs changed on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_idle();
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_sel = '0; d_addr = '0; d_wdata = '0;
        m_ack = 1'b0; m_rdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; if_req = 1'b1; d_req = 1'b1; m_ack = 1'b1; m_rdata = '1;
        tick(); tick();
        n_tests++;
        if ({m_req, m_we, m_sel, m_addr, m_wdata} !== 70'h0) begin
            n_fail++; $display("FAIL reset_m_bus got=%h exp=0", {m_req, m_we, m_sel, m_addr, m_wdata});
        end
        n_tests++;
        if ({if_ack, d_ack, bus_err} !== 3'b000) begin
            n_fail++; $display("FAIL reset_strobes got=%b exp=000", {if_ack, d_ack, bus_err});
        end
        n_tests++;
        if ({if_rdata, d_rdata} !== 64'h0) begin
            n_fail++; $display("FAIL reset_rdata got=%h exp=0", {if_rdata, d_rdata});
        end
        drive_idle(); rst = 1'b0;
        tick();
        n_tests++;
        if (m_req !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle_m_req got=%b exp=0", m_req);
        end
    endtask

    task automatic test_single_fetch();
        if_req = 1'b1; if_addr = 32'h0000_0010;
        #1;
        n_tests++;
        if (stall_req !== 1'b1) begin
            n_fail++; $display("FAIL fetch_stall_on_req got=%b exp=1", stall_req);
        end
        tick();
        n_tests++;
        if ({m_req, m_we, m_sel, m_addr, m_wdata} !== {1'b1, 1'b0, 4'hF, 32'h10, 32'h0}) begin
            n_fail++; $display("FAIL fetch_m_bus got=%h exp=%h", {m_req, m_we, m_sel, m_addr, m_wdata},
                               {1'b1, 1'b0, 4'hF, 32'h10, 32'h0});
        end
        n_tests++;
        if ({stall_req, if_ack} !== 2'b10) begin
            n_fail++; $display("FAIL fetch_wait_stall got=%b exp=10", {stall_req, if_ack});
        end
        m_ack = 1'b1; m_rdata = 32'h3C01_0001;
        tick();
        n_tests++;
        if ({if_ack, d_ack, bus_err, m_req, stall_req} !== 5'b10000) begin
            n_fail++; $display("FAIL fetch_ack got=%b exp=10000", {if_ack, d_ack, bus_err, m_req, stall_req});
        end
        n_tests++;
        if (if_rdata !== 32'h3C01_0001) begin
            n_fail++; $display("FAIL fetch_rdata got=%h exp=3c010001", if_rdata);
        end
        if_req = 1'b0; m_ack = 1'b0; m_rdata = '0;
        tick();
        n_tests++;
        if ({if_ack, if_rdata} !== {1'b0, 32'h3C01_0001}) begin
            n_fail++; $display("FAIL fetch_hold got=%h exp=%h", {if_ack, if_rdata}, {1'b0, 32'h3C01_0001});
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] r1;
        int t_d, t_i;
        r1 = $urandom | 32'h1;
        if_req = 1'b1; if_addr = 32'h20;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_sel = 4'hF;
        tick();
        n_tests++;
        if ({m_req, m_we, m_sel, m_addr, m_wdata} !== {1'b1, 1'b1, 4'hF, 32'h100, 32'hDEAD_BEEF}) begin
            n_fail++; $display("FAIL simul_data_first got=%h exp=%h", {m_req, m_we, m_sel, m_addr, m_wdata},
                               {1'b1, 1'b1, 4'hF, 32'h100, 32'hDEAD_BEEF});
        end
        m_ack = 1'b1; m_rdata = r1;
        tick();
        t_d = cyc_no;
        n_tests++;
        if ({d_ack, if_ack, d_rdata} !== {2'b10, r1}) begin
            n_fail++; $display("FAIL simul_d_ack got=%h exp=%h", {d_ack, if_ack, d_rdata}, {2'b10, r1});
        end
        d_req = 1'b0; d_we = 1'b0; m_ack = 1'b0;
        tick();
        n_tests++;
        if ({m_req, stall_req} !== 2'b01) begin
            n_fail++; $display("FAIL simul_gap got=%b exp=01", {m_req, stall_req});
        end
        tick();
        n_tests++;
        if ({m_req, m_we, m_sel, m_addr, m_wdata} !== {1'b1, 1'b0, 4'hF, 32'h20, 32'h0}) begin
            n_fail++; $display("FAIL simul_fetch_second got=%h exp=%h", {m_req, m_we, m_sel, m_addr, m_wdata},
                               {1'b1, 1'b0, 4'hF, 32'h20, 32'h0});
        end
        m_ack = 1'b1; m_rdata = ~r1;
        tick();
        t_i = cyc_no;
        n_tests++;
        if ({if_ack, if_rdata, d_rdata} !== {1'b1, ~r1, r1}) begin
            n_fail++; $display("FAIL simul_i_ack got=%h exp=%h", {if_ack, if_rdata, d_rdata}, {1'b1, ~r1, r1});
        end
        n_tests++;
        if (t_i - t_d !== 3) begin
            n_fail++; $display("FAIL simul_ack_spacing got=%0d exp=3", t_i - t_d);
        end
        drive_idle();
        tick();
    endtask

    task automatic test_starvation();
        bit exp_d;
        if_req = 1'b1; if_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b1; d_sel = 4'h3; d_addr = 32'h200; d_wdata = 32'h55;
        for (int t = 0; t < 8; t++) begin
            exp_d = ((t % 4) != 3);
            tick();
            n_tests++;
            if ({m_req, m_we, m_addr} !== {1'b1, exp_d, (exp_d ? d_addr : 32'h40)}) begin
                n_fail++; $display("FAIL starve_grant_%0d got=%h exp=%h", t, {m_req, m_we, m_addr},
                                   {1'b1, exp_d, (exp_d ? d_addr : 32'h40)});
            end
            m_ack = 1'b1; m_rdata = 32'(t + 1);
            tick();
            n_tests++;
            if ({if_ack, d_ack} !== {~exp_d, exp_d}) begin
                n_fail++; $display("FAIL starve_ack_%0d got=%b exp=%b", t, {if_ack, d_ack}, {~exp_d, exp_d});
            end
            m_ack = 1'b0;
            if (exp_d) d_addr = d_addr + 32'h4;
            tick();
        end
        drive_idle();
        tick();
    endtask

    task automatic test_timeout();
        d_req = 1'b1; d_we = 1'b0; d_sel = 4'hF; d_addr = 32'h300;
        for (int i = 0; i < TIMEOUT; i++) begin
            tick();
            n_tests++;
            if ({m_req, d_ack, bus_err} !== 3'b100) begin
                n_fail++; $display("FAIL timeout_wait_%0d got=%b exp=100", i, {m_req, d_ack, bus_err});
            end
        end
        tick();
        n_tests++;
        if ({m_req, d_ack, bus_err, if_ack, d_rdata} !== {4'b0110, 32'h0}) begin
            n_fail++; $display("FAIL timeout_fire got=%h exp=%h", {m_req, d_ack, bus_err, if_ack, d_rdata},
                               {4'b0110, 32'h0});
        end
        d_req = 1'b0;
        tick();
        n_tests++;
        if ({m_req, d_ack, bus_err} !== 3'b000) begin
            n_fail++; $display("FAIL timeout_after got=%b exp=000", {m_req, d_ack, bus_err});
        end
        tick();
        // An ack arriving in the last permitted grant cycle must still complete normally.
        d_req = 1'b1;
        for (int i = 0; i < TIMEOUT; i++) begin
            tick();
            if (i == TIMEOUT - 1) begin
                m_ack = 1'b1; m_rdata = 32'hA5A5_0F0F;
            end
        end
        tick();
        n_tests++;
        if ({d_ack, bus_err, d_rdata} !== {2'b10, 32'hA5A5_0F0F}) begin
            n_fail++; $display("FAIL timeout_last_cycle_ack got=%h exp=%h", {d_ack, bus_err, d_rdata},
                               {2'b10, 32'hA5A5_0F0F});
        end
        drive_idle();
        tick();
    endtask

    task automatic test_reset_mid_grant();
        d_req = 1'b1; d_we = 1'b1; d_sel = 4'hF; d_addr = 32'h400; d_wdata = 32'h1;
        tick(); tick();
        n_tests++;
        if (m_req !== 1'b1) begin
            n_fail++; $display("FAIL midrst_granted got=%b exp=1", m_req);
        end
        rst = 1'b1;
        tick();
        n_tests++;
        if ({m_req, d_ack, bus_err} !== 3'b000) begin
            n_fail++; $display("FAIL midrst_abort got=%b exp=000", {m_req, d_ack, bus_err});
        end
        rst = 1'b0; drive_idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if ({m_req, d_ack, bus_err} !== 3'b000) begin
                n_fail++; $display("FAIL midrst_quiet_%0d got=%b exp=000", i, {m_req, d_ack, bus_err});
            end
        end
        if_req = 1'b1; if_addr = 32'h80;
        tick();
        n_tests++;
        if ({m_req, m_we, m_addr} !== {2'b10, 32'h80}) begin
            n_fail++; $display("FAIL midrst_fetch_grant got=%h exp=%h", {m_req, m_we, m_addr}, {2'b10, 32'h80});
        end
        m_ack = 1'b1; m_rdata = 32'h1234;
        tick();
        n_tests++;
        if ({if_ack, if_rdata} !== {1'b1, 32'h1234}) begin
            n_fail++; $display("FAIL midrst_fetch_ack got=%h exp=%h", {if_ack, if_rdata}, {1'b1, 32'h1234});
        end
        drive_idle();
        tick();
    endtask

    // Reference model: a transfer is free, in flight (counting grant cycles), or completing.
    typedef enum int {M_FREE, M_BUSY, M_DONE} xfer_e;
    xfer_e       x_phase;
    bit          x_is_d, x_err;
    int          x_age, x_passed;
    logic        x_we;
    logic [3:0]  x_sel;
    logic [31:0] x_addr, x_wdata, x_if_rd, x_d_rd;

    task automatic model_reset();
        x_phase = M_FREE; x_is_d = 1'b0; x_err = 1'b0; x_age = 0; x_passed = 0;
        x_if_rd = '0; x_d_rd = '0;
    endtask

    task automatic test_random();
        bit exp_ia, exp_da, exp_be, exp_stall, slow;
        rst = 1'b1; drive_idle();
        tick();
        rst = 1'b0; model_reset();
        for (int i = 0; i < 4000; i++) begin
            tick();
            exp_ia    = (x_phase == M_DONE) && !x_is_d;
            exp_da    = (x_phase == M_DONE) && x_is_d;
            exp_be    = (x_phase == M_DONE) && x_err;
            exp_stall = (if_req && !exp_ia) || (d_req && !exp_da);
            n_tests++;
            if ({m_req, if_ack, d_ack, bus_err, stall_req} !== {x_phase == M_BUSY, exp_ia, exp_da, exp_be, exp_stall}) begin
                n_fail++; $display("FAIL rand_ctrl cyc=%0d got=%b exp=%b", i, {m_req, if_ack, d_ack, bus_err, stall_req},
                                   {x_phase == M_BUSY, exp_ia, exp_da, exp_be, exp_stall});
            end
            n_tests++;
            if ({if_rdata, d_rdata} !== {x_if_rd, x_d_rd}) begin
                n_fail++; $display("FAIL rand_rdata cyc=%0d got=%h exp=%h", i, {if_rdata, d_rdata}, {x_if_rd, x_d_rd});
            end
            if (x_phase == M_BUSY) begin
                n_tests++;
                if ({m_we, m_sel, m_addr, m_wdata} !== {x_we, x_sel, x_addr, x_wdata}) begin
                    n_fail++; $display("FAIL rand_m_bus cyc=%0d got=%h exp=%h", i, {m_we, m_sel, m_addr, m_wdata},
                                       {x_we, x_sel, x_addr, x_wdata});
                end
            end

            // Next-cycle stimulus: requesters hold until acked, then withdraw.
            if (exp_ia) if_req = 1'b0;
            else if (!if_req && $urandom_range(2) == 0) begin
                if_req = 1'b1; if_addr = $urandom;
            end
            if (exp_da) d_req = 1'b0;
            else if (!d_req && $urandom_range(1) == 0) begin
                d_req = 1'b1; d_we = 1'($urandom); d_sel = 4'($urandom);
                d_addr = $urandom; d_wdata = $urandom;
            end
            slow    = ((i / 500) % 2) == 1;
            m_ack   = (x_phase == M_BUSY) ? (slow ? ($urandom_range(39) == 0) : ($urandom_range(1) == 0))
                                          : ($urandom_range(5) == 0);
            m_rdata = $urandom;
            rst     = ($urandom_range(249) == 0);
            if (rst) begin
                if_req = 1'b0; d_req = 1'b0;
            end

            if (rst) model_reset();
            else begin
                case (x_phase)
                    M_FREE: begin
                        if (d_req && (!if_req || x_passed < STARVE_LIMIT)) begin
                            x_phase = M_BUSY; x_is_d = 1'b1; x_age = 1;
                            x_passed = if_req ? ((x_passed < STARVE_LIMIT) ? x_passed + 1 : STARVE_LIMIT) : 0;
                            x_we = d_we; x_sel = d_sel; x_addr = d_addr; x_wdata = d_wdata;
                        end else if (if_req) begin
                            x_phase = M_BUSY; x_is_d = 1'b0; x_age = 1; x_passed = 0;
                            x_we = 1'b0; x_sel = 4'hF; x_addr = if_addr; x_wdata = '0;
                        end
                    end
                    M_BUSY: begin
                        if (m_ack || x_age == TIMEOUT) begin
                            x_phase = M_DONE; x_err = !m_ack;
                            if (x_is_d) x_d_rd = m_ack ? m_rdata : 32'h0;
                            else        x_if_rd = m_ack ? m_rdata : 32'h0;
                        end else x_age++;
                    end
                    default: begin
                        x_phase = M_FREE; x_err = 1'b0;
                    end
                endcase
            end
        end
        rst = 1'b0; drive_idle();
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before the bench completed");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_idle();
        rst = 1'b1;
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_starvation();
        test_timeout();
        test_reset_mid_grant();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
